halfband_interp_11: RTL and testbench
=====================================

HALFBAND_INTERP_11 -- requirements
Module: halfband_interp_11

Interface
REQ-001 SHALL have parameter CH, default 8, number of 24-bit channels processed in parallel; every requirement below uses CH=8.
REQ-002 SHALL have port c  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port id  input  24*CH (192)  input samples, signed 24-bit per channel, channel k at bits [24k+23:24k].
REQ-005 SHALL have port iv  input  1  input valid, one-cycle strobe per input sample set.
REQ-006 SHALL have port od  output  24*CH (192)  output samples, signed 24-bit per channel, same packing as id.
REQ-007 SHALL have port ov  output  1  output valid, one-cycle pulse per output sample set.
REQ-008 SHALL have port busy  output  1  high while an accepted input is being processed.
REQ-009 SHALL have port ovf  output  1  sticky flag: an input strobe arrived while busy.

Function
REQ-010 SHALL be an 8-channel 2x interpolating halfband filter, 11 taps, 18-bit signed coefficients c1=1738, c3=-13376, c5=77174, center 2^17 (unity).
REQ-011 SHALL keep a per-channel history x[n]..x[n-5] (6 sets of 192 bits); accepted input shifts in as x[n].
REQ-012 SHALL accept id when iv=1 and busy=0 (cycle 0); busy rises cycle 1 and falls after cycle 10.
REQ-013 SHALL ignore id when iv=1 and busy=1, leaving history unchanged, and set ovf=1 until reset.
REQ-014 SHALL emit two outputs per accepted input, even phase first, then odd phase.
REQ-015 Even output SHALL equal x[n-3] exactly, od valid with ov=1 at cycle 2.
REQ-016 Odd output SHALL be acc = c1*(x[n]+x[n-5]) + c3*(x[n-1]+x[n-4]) + c5*(x[n-2]+x[n-3]), od = (acc + 2^16) >>> 17, with ov=1 at cycle 10.
REQ-017 SHALL compute odd output with one shared coefficient per cycle and one 24x18 signed MAC per channel, six MAC cycles, accumulator at least 45 bits, no intermediate truncation.
REQ-018 SHALL use sequencer states IDLE, MAC0..MAC5, RND, OUT; IDLE->MAC0 on accept, MACi->MACi+1, MAC5->RND->OUT->IDLE.
REQ-019 SHALL hold od constant between ov pulses; ov never high on two consecutive cycles.
REQ-020 Minimum iv spacing for loss-free operation SHALL be 11 cycles; iv in the IDLE cycle that immediately follows OUT SHALL be accepted.
REQ-021 History pointer SHALL wrap modulo 6 (or shift register) with no gap at wrap.

Reset
REQ-022 Reset assertion SHALL asynchronously force state=IDLE, history to all zeros, od=0, ov=0, busy=0, ovf=0.
REQ-023 Reset mid-operation SHALL abort the sequence; no ov pulse follows until a new input is accepted after reset release.
REQ-024 iv while reset is high SHALL be ignored.

Configuration
REQ-025 Macro HALFBAND_INTERP_11_SAT_EN defined: odd output SHALL saturate to [-8388608, 8388607] after rounding.
REQ-026 Macro HALFBAND_INTERP_11_SAT_EN undefined: odd output SHALL be the low 24 bits of the rounded result (two's-complement wrap); even output unaffected either way.

Verification
REQ-027 Impulse: ch0 input 131072 once, then zeros, iv every 11 cycles -> successive odd outputs ch0 = 1738, -13376, 77174, 77174, -13376, 1738; even output 131072 on 4th input; other channels 0.
REQ-028 DC: all channels constant 100000 for 8 inputs -> from 6th input on, even=100000 and odd=100000 every channel; ov at cycles 2 and 10 of each input.
REQ-029 Overflow: ch0 sequence 8388607, -8388608, 8388607, 8388607, -8388608, 8388607 -> 6th odd output = 8388607 with SAT_EN, -4964353 without.
REQ-030 Overrun: iv at cycle 0 and cycle 5 -> second input dropped, ovf=1 from cycle 6, outputs match single-input case, ovf held until reset.
REQ-031 Reset mid-op: reset pulsed at cycle 4 after accept -> no ov at cycle 10, od=0, busy=0; next input with zero history gives even=0.
REQ-032 Back-to-back: iv exactly at cycles 0 and 11 -> both accepted, ov at cycles 2, 10, 13, 21, ovf stays 0.

Source files
------------

// File: rtl/halfband_interp_11.sv
// 2x interpolating 11-tap halfband filter, CH parallel 24-bit channels, one shared-coefficient MAC per channel.
// Define HALFBAND_INTERP_11_SAT_EN to saturate the odd-phase output; otherwise it wraps to 24 bits.
module halfband_interp_11 #(
    parameter int CH = 8
) (
    input  logic            c,
    input  logic            reset,
    input  logic [24*CH-1:0] id,
    input  logic            iv,
    output logic [24*CH-1:0] od,
    output logic            ov,
    output logic            busy,
    output logic            ovf,
    output logic [3:0]      fsm_state
);

    // Handshake: a sample set is taken when iv=1 and busy=0; iv while busy is dropped and latches ovf.
    typedef enum logic [3:0] {
        IDLE = 4'd0, MAC0, MAC1, MAC2, MAC3, MAC4, MAC5, RND, OUT
    } state_t;

    state_t state_q, state_d;
    logic [1:0] lead;
    logic accept;
    logic [2:0] tap;
    logic signed [17:0] coef;
    logic signed [23:0] hist [6][CH];
    logic [24*CH-1:0] even_vec;
    logic [24*CH-1:0] odd_vec;

    assign accept    = iv && !busy;
    assign fsm_state = state_q;

    // lead carries an accepted set through the even-output cycles before the MAC phase starts
    always_ff @(posedge c or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            lead    <= 2'b00;
        end else begin
            state_q <= state_d;
            lead    <= {lead[0], accept};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (lead[1]) state_d = MAC0;
            MAC0:    state_d = MAC1;
            MAC1:    state_d = MAC2;
            MAC2:    state_d = MAC3;
            MAC3:    state_d = MAC4;
            MAC4:    state_d = MAC5;
            MAC5:    state_d = RND;
            RND:     state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE) || (lead != 2'b00);
        tap  = 3'd0;
        coef = 18'sd0;
        case (state_q)
            MAC0: begin tap = 3'd0; coef = 18'sd1738;   end
            MAC1: begin tap = 3'd1; coef = -18'sd13376; end
            MAC2: begin tap = 3'd2; coef = 18'sd77174;  end
            MAC3: begin tap = 3'd3; coef = 18'sd77174;  end
            MAC4: begin tap = 3'd4; coef = -18'sd13376; end
            MAC5: begin tap = 3'd5; coef = 18'sd1738;   end
            default: begin tap = 3'd0; coef = 18'sd0; end
        endcase
    end

    always_ff @(posedge c or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < 6; j++)
                for (int k = 0; k < CH; k++)
                    hist[j][k] <= '0;
        end else if (accept) begin
            for (int k = 0; k < CH; k++)
                hist[0][k] <= id[24*k +: 24];
            for (int j = 1; j < 6; j++)
                for (int k = 0; k < CH; k++)
                    hist[j][k] <= hist[j-1][k];
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic signed [41:0] prod;
        logic signed [45:0] acc;
        logic [23:0] odd;

        assign prod = hist[tap][k] * coef;
        assign even_vec[24*k +: 24] = hist[3][k];
        assign odd_vec[24*k +: 24]  = odd;

        always_ff @(posedge c or posedge reset) begin
            if (reset)
                acc <= '0;
            else if (state_q == MAC0)
                acc <= 46'(prod);
            else if (state_q inside {MAC1, MAC2, MAC3, MAC4, MAC5})
                acc <= acc + 46'(prod);
        end

`ifdef HALFBAND_INTERP_11_SAT_EN
        logic signed [28:0] sh;
        assign sh = 29'((acc + 46'sd65536) >>> 17);
        always_comb begin
            if (sh > 29'sd8388607)
                odd = 24'h7FFFFF;
            else if (sh < -29'sd8388608)
                odd = 24'h800000;
            else
                odd = sh[23:0];
        end
`else
        assign odd = 24'((acc + 46'sd65536) >>> 17);
`endif
    end

    always_ff @(posedge c or posedge reset) begin
        if (reset) begin
            od  <= '0;
            ov  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            ov <= lead[0] || (state_q == RND);
            if (lead[0])
                od <= even_vec;
            else if (state_q == RND)
                od <= odd_vec;
            if (iv && busy)
                ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_halfband_interp_11.sv
// Scoreboard bench for halfband_interp_11: stimulus pushes expected od and arrival cycle, monitor pops on ov.
module tb_halfband_interp_11;

  logic         c;
  logic         reset;
  logic [191:0] id;
  logic         iv;
  logic [191:0] od;
  logic         ov;
  logic         busy;
  logic         ovf;
  logic [3:0]   fsm_state;

  halfband_interp_11 #(.CH(8)) dut (
    .c(c), .reset(reset), .id(id), .iv(iv), .od(od), .ov(ov),
    .busy(busy), .ovf(ovf), .fsm_state(fsm_state)
  );

  // clock / reset block
  initial c = 1'b0;
  always #5 c = ~c;

  int cyc = 0;
  always @(posedge c) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  logic [191:0] exp_q[$];
  int exp_t_q[$];
  logic [191:0] hist_m[6];
  int busy_end = -100;
  logic prev_ov = 1'b0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [191:0] ch0(input int v);
    logic [191:0] r;
    logic [23:0] t;
    t = v[23:0];
    r = '0;
    r[23:0] = t;
    return r;
  endfunction

  // reference odd phase straight from the filter equation
  function automatic logic [191:0] odd_ref();
    logic [191:0] res;
    logic signed [23:0] s [6];
    longint a, r;
    res = '0;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 6; j++) s[j] = hist_m[j][24*k +: 24];
      a = 64'sd1738 * (longint'(s[0]) + longint'(s[5]))
        - 64'sd13376 * (longint'(s[1]) + longint'(s[4]))
        + 64'sd77174 * (longint'(s[2]) + longint'(s[3]));
      r = (a + 64'sd65536) >>> 17;
`ifdef HALFBAND_INTERP_11_SAT_EN
      if (r > 64'sd8388607) r = 64'sd8388607;
      if (r < -64'sd8388608) r = -64'sd8388608;
`endif
      res[24*k +: 24] = r[23:0];
    end
    return res;
  endfunction

  // driver: one iv strobe; if the bench expects acceptance, update model and push even/odd
  task automatic send(input logic [191:0] d, input bit use_hand, input logic [191:0] odd_hand);
    int t0;
    @(posedge c);
    #1;
    id = d;
    iv = 1'b1;
    t0 = cyc;
    if (t0 > busy_end) begin
      for (int j = 5; j > 0; j--) hist_m[j] = hist_m[j-1];
      hist_m[0] = d;
      exp_q.push_back(hist_m[3]);
      exp_t_q.push_back(t0 + 2);
      exp_q.push_back(use_hand ? odd_hand : odd_ref());
      exp_t_q.push_back(t0 + 10);
      busy_end = t0 + 10;
    end
    @(posedge c);
    #1;
    iv = 1'b0;
    id = '0;
  endtask

  task automatic clear_model();
    for (int j = 0; j < 6; j++) hist_m[j] = '0;
    exp_q.delete();
    exp_t_q.delete();
    busy_end = -100;
  endtask

  task automatic do_reset();
    @(posedge c);
    #1;
    reset = 1'b1;
    clear_model();
    #2;
    reset = 1'b0;
  endtask

  // monitor / scoreboard
  always @(negedge c) begin
    if (ov) begin
      chk_int("ov_back_to_back", int'(prev_ov), 0);
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_ov: got ov=1 with od %h, expected no output (cycle %0d)", od, cyc);
      end else begin
        chk("od", od, exp_q.pop_front());
        chk_int("ov_cycle", cyc, exp_t_q.pop_front());
      end
    end
    prev_ov <= ov;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int imp_odd [7];
    logic [191:0] dc;
    logic [191:0] zero;
    imp_odd = '{1738, -13376, 77174, 77174, -13376, 1738, 0};
    dc = {8{24'd100000}};
    zero = '0;
    reset = 1'b1;
    iv = 1'b0;
    id = '0;
    clear_model();
    repeat (2) @(posedge c);
    #1;
    chk("reset_od", od, zero);
    chk_int("reset_ov", int'(ov), 0);
    chk_int("reset_busy", int'(busy), 0);
    chk_int("reset_ovf", int'(ovf), 0);
    iv = 1'b1;
    @(posedge c);
    #1;
    chk_int("iv_in_reset_busy", int'(busy), 0);
    iv = 1'b0;
    reset = 1'b0;

    // impulse response
    do_reset();
    for (int i = 0; i < 7; i++) begin
      send(i == 0 ? ch0(131072) : zero, 1'b1, ch0(imp_odd[i]));
      repeat (9) @(posedge c);
    end
    repeat (2) @(posedge c);

    // DC gain
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(dc, i >= 5, dc);
      repeat (9) @(posedge c);
    end
    repeat (2) @(posedge c);

    // overflow on the odd phase
    do_reset();
    begin
      int ov_seq [6];
      ov_seq = '{8388607, -8388608, 8388607, 8388607, -8388608, 8388607};
      for (int i = 0; i < 6; i++) begin
`ifdef HALFBAND_INTERP_11_SAT_EN
        send(ch0(ov_seq[i]), i == 5, ch0(8388607));
`else
        send(ch0(ov_seq[i]), i == 5, ch0(-4964353));
`endif
        repeat (9) @(posedge c);
      end
    end
    repeat (2) @(posedge c);

    // overrun: second strobe at cycle 5 is dropped
    do_reset();
    send(ch0(131072), 1'b1, ch0(1738));
    repeat (3) @(posedge c);
    #1;
    chk_int("ovf_before_overrun", int'(ovf), 0);
    send(ch0(555555), 1'b0, zero);
    chk_int("ovf_after_overrun", int'(ovf), 1);
    chk_int("busy_during_op", int'(busy), 1);
    repeat (4) @(posedge c);
    send(zero, 1'b1, ch0(-13376));
    repeat (10) @(posedge c);
    #1;
    chk_int("ovf_sticky", int'(ovf), 1);
    do_reset();
    #1;
    chk_int("ovf_cleared", int'(ovf), 0);

    // reset in the middle of a sequence
    do_reset();
    send({8{24'd4000}}, 1'b0, zero);
    repeat (3) @(posedge c);
    #1;
    reset = 1'b1;
    clear_model();
    #1;
    chk("midreset_od", od, zero);
    chk_int("midreset_busy", int'(busy), 0);
    chk_int("midreset_state", int'(fsm_state), 0);
    @(posedge c);
    #1;
    reset = 1'b0;
    repeat (8) @(posedge c);
    send({8{24'd2500}}, 1'b0, zero);
    repeat (11) @(posedge c);

    // back-to-back accepts exactly 11 cycles apart
    do_reset();
    send(ch0(-70000), 1'b0, zero);
    repeat (9) @(posedge c);
    send({8{24'd12345}}, 1'b0, zero);
    repeat (12) @(posedge c);
    #1;
    chk_int("b2b_ovf", int'(ovf), 0);

    repeat (4) @(posedge c);
    chk_int("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
